coin_credit_ctrl: RTL and testbench

//  Front-end of the claw machine, upstream of the top-level game FSM (INIT/PLAY/WAIT_RESULT).

---
 rtl/coin_credit_ctrl.sv | 176 +++++++++++++++++
 tb/tb_coin_credit_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_credit_ctrl.sv
`default_nettype none
// ============================================================================
// coin_credit_ctrl : coin debounce, credit bank, play grant and play timer
// Revision: 1.0
// ============================================================================
module coin_credit_ctrl #(
  parameter int CLK_HZ         = 100_000_000,
  parameter int DEBOUNCE_CYC   = 6,
  parameter int MAX_CREDIT     = 9,
  parameter int COINS_PER_PLAY = 1,
  parameter int PLAY_SECONDS   = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin_in,
  input  logic       start_req,
  input  logic       play_done,
  output logic       play_grant,
  output logic       play_active,
  output logic       time_up,
  output logic       coin_reject,
  output logic [3:0] credits,
  output logic [6:0] seconds_left
);

  localparam int C_CNT_W  = $clog2(DEBOUNCE_CYC + 1);
  localparam int C_TICK_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  localparam logic [C_CNT_W-1:0]  C_DB_LAST   = C_CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [C_TICK_W-1:0] C_TICK_LAST = C_TICK_W'(CLK_HZ - 1);
  localparam logic [3:0]          C_MAX       = 4'(MAX_CREDIT);
  localparam logic [3:0]          C_COST      = 4'(COINS_PER_PLAY);
  localparam logic [6:0]          C_SECS      = 7'(PLAY_SECONDS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PLAYING = 2'd1,
    S_TIMEOUT = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 sync1_q, sync2_q, filt_q, coin_evt_q;
  logic [C_CNT_W-1:0]   db_cnt_q;
  logic [C_TICK_W-1:0]  tick_q, tick_d;
  logic [6:0]           secs_q, secs_d;
  logic [3:0]           credits_q, credits_d;
  logic                 grant_q, grant_d;
  logic                 active_q, active_d;
  logic                 time_up_q, time_up_d;
  logic                 reject_q, reject_d;
  logic [3:0]           w_ded;
  logic [3:0]           w_after_ded;

  // Coin path: a level is accepted once sync2 has differed from the filtered
  // level for DEBOUNCE_CYC consecutive samples; only a rising accept is a coin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      filt_q     <= 1'b0;
      db_cnt_q   <= '0;
      coin_evt_q <= 1'b0;
    end else begin
      sync1_q    <= coin_in;
      sync2_q    <= sync1_q;
      coin_evt_q <= 1'b0;
      if (sync2_q == filt_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == C_DB_LAST) begin
        filt_q     <= sync2_q;
        db_cnt_q   <= '0;
        coin_evt_q <= sync2_q;
      end else begin
        db_cnt_q <= db_cnt_q + C_CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = 1'b0;
    active_d  = active_q;
    time_up_d = 1'b0;
    secs_d    = secs_q;
    tick_d    = tick_q;
    w_ded     = 4'd0;
    case (state_q)
      S_IDLE: begin
        if (start_req && (credits_q >= C_COST)) begin
          state_d  = S_PLAYING;
          grant_d  = 1'b1;
          active_d = 1'b1;
          secs_d   = C_SECS;
          tick_d   = '0;
          w_ded    = C_COST;
        end
      end
      S_PLAYING: begin
        if (play_done) begin
          state_d  = S_IDLE;
          active_d = 1'b0;
          secs_d   = 7'd0;
          tick_d   = '0;
        end else if (tick_q == C_TICK_LAST) begin
          tick_d = '0;
          secs_d = secs_q - 7'd1;
          if (secs_q == 7'd1) begin
            state_d   = S_TIMEOUT;
            time_up_d = 1'b1;
          end
        end else begin
          tick_d = tick_q + C_TICK_W'(1);
        end
      end
      S_TIMEOUT: begin
        secs_d = 7'd0;
        if (play_done) begin
          state_d  = S_IDLE;
          active_d = 1'b0;
        end
      end
      default: begin
        state_d  = S_IDLE;
        active_d = 1'b0;
        secs_d   = 7'd0;
        tick_d   = '0;
      end
    endcase
  end

  // Deduction is applied before the coin so a full bank can still take a coin
  // on the same cycle it pays for a play.
  always_comb begin
    w_after_ded = credits_q - w_ded;
    credits_d   = w_after_ded;
    reject_d    = 1'b0;
    if (coin_evt_q) begin
      if (w_after_ded >= C_MAX) begin
        reject_d = 1'b1;
      end else begin
        credits_d = w_after_ded + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      tick_q    <= '0;
      secs_q    <= 7'd0;
      credits_q <= 4'd0;
      grant_q   <= 1'b0;
      active_q  <= 1'b0;
      time_up_q <= 1'b0;
      reject_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      secs_q    <= secs_d;
      credits_q <= credits_d;
      grant_q   <= grant_d;
      active_q  <= active_d;
      time_up_q <= time_up_d;
      reject_q  <= reject_d;
    end
  end

  assign play_grant   = grant_q;
  assign play_active  = active_q;
  assign time_up      = time_up_q;
  assign coin_reject  = reject_q;
  assign credits      = credits_q;
  assign seconds_left = secs_q;

endmodule
`default_nettype wire

// File: tb/tb_coin_credit_ctrl.sv
`default_nettype none
// ============================================================================
// tb_coin_credit_ctrl : directed vector bench for coin_credit_ctrl
// Revision: 1.0
// ============================================================================
module tb_coin_credit_ctrl;

  localparam int OP_START = 0;
  localparam int OP_DONE  = 1;
  localparam int OP_WAIT  = 2;
  localparam int OP_COIN  = 3;
  localparam int NV       = 15;

  typedef struct {
    int op;
    int arg;
    int cr;
    int act;
    int secs;
    int grant;
    int tu;
    int n_grant;
    int n_tu;
    int n_rej;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       coin_in;
  logic       start_req;
  logic       play_done;
  logic       play_grant;
  logic       play_active;
  logic       time_up;
  logic       coin_reject;
  logic [3:0] credits;
  logic [6:0] seconds_left;

  int total = 0;
  int bad   = 0;
  int n_grant = 0;
  int n_tu    = 0;
  int n_rej   = 0;
  logic pg_prev = 1'b0;
  logic tu_prev = 1'b0;
  logic rj_prev = 1'b0;
  vec_t tbl[NV];

  coin_credit_ctrl #(
    .CLK_HZ        (20),
    .DEBOUNCE_CYC  (4),
    .MAX_CREDIT    (9),
    .COINS_PER_PLAY(1),
    .PLAY_SECONDS  (30)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .coin_in     (coin_in),
    .start_req   (start_req),
    .play_done   (play_done),
    .play_grant  (play_grant),
    .play_active (play_active),
    .time_up     (time_up),
    .coin_reject (coin_reject),
    .credits     (credits),
    .seconds_left(seconds_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic insert_coin();
    coin_in = 1'b1;
    step(10);
    coin_in = 1'b0;
    step(10);
  endtask

  // Pulse counters and single-cycle width checks on the pulse outputs.
  always begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      pg_prev = 1'b0;
      tu_prev = 1'b0;
      rj_prev = 1'b0;
    end else begin
      if (play_grant) begin
        n_grant++;
        chk("grant width", {31'd0, pg_prev}, 0);
      end
      if (time_up) begin
        n_tu++;
        chk("time_up width", {31'd0, tu_prev}, 0);
      end
      if (coin_reject) begin
        n_rej++;
        chk("reject width", {31'd0, rj_prev}, 0);
      end
      pg_prev = play_grant;
      tu_prev = time_up;
      rj_prev = coin_reject;
    end
  end

  initial begin
    tbl[0]  = '{OP_START, 0,   0, 1, 30, 1, 0, 1, 0, 0};
    tbl[1]  = '{OP_WAIT,  20,  0, 1, 29, 0, 0, 1, 0, 0};
    tbl[2]  = '{OP_WAIT,  579, 0, 1, 1,  0, 0, 1, 0, 0};
    tbl[3]  = '{OP_WAIT,  1,   0, 1, 0,  0, 1, 1, 1, 0};
    tbl[4]  = '{OP_WAIT,  1,   0, 1, 0,  0, 0, 1, 1, 0};
    tbl[5]  = '{OP_START, 0,   0, 1, 0,  0, 0, 1, 1, 0};
    tbl[6]  = '{OP_DONE,  0,   0, 0, 0,  0, 0, 1, 1, 0};
    tbl[7]  = '{OP_DONE,  0,   0, 0, 0,  0, 0, 1, 1, 0};
    tbl[8]  = '{OP_START, 0,   0, 0, 0,  0, 0, 1, 1, 0};
    tbl[9]  = '{OP_COIN,  9,   9, 0, 0,  0, 0, 1, 1, 0};
    tbl[10] = '{OP_COIN,  1,   9, 0, 0,  0, 0, 1, 1, 1};
    tbl[11] = '{OP_START, 0,   8, 1, 30, 1, 0, 2, 1, 1};
    tbl[12] = '{OP_WAIT,  25,  8, 1, 29, 0, 0, 2, 1, 1};
    tbl[13] = '{OP_DONE,  0,   8, 0, 0,  0, 0, 2, 1, 1};
    tbl[14] = '{OP_COIN,  1,   9, 0, 0,  0, 0, 2, 1, 1};

    rst_n     = 1'b0;
    coin_in   = 1'b0;
    start_req = 1'b0;
    play_done = 1'b0;
    step(3);
    chk("reset grant",   {31'd0, play_grant}, 0);
    chk("reset active",  {31'd0, play_active}, 0);
    chk("reset time_up", {31'd0, time_up}, 0);
    chk("reset reject",  {31'd0, coin_reject}, 0);
    chk("reset credits", {28'd0, credits}, 0);
    chk("reset secs",    {25'd0, seconds_left}, 0);
    rst_n = 1'b1;
    step(2);

    // Three short glitches shorter than the filter, then a clean held coin.
    for (int k = 0; k < 3; k++) begin
      coin_in = 1'b1;
      step(1);
      coin_in = 1'b0;
      step(1);
    end
    coin_in = 1'b1;
    step(10);
    coin_in = 1'b0;
    step(10);
    chk("bounce credits", {28'd0, credits}, 1);
    chk("bounce rejects", n_rej, 0);

    for (int i = 0; i < NV; i++) begin
      case (tbl[i].op)
        OP_START: begin start_req = 1'b1; step(1); start_req = 1'b0; end
        OP_DONE:  begin play_done = 1'b1; step(1); play_done = 1'b0; end
        OP_WAIT:  step(tbl[i].arg);
        default:  repeat (tbl[i].arg) insert_coin();
      endcase
      chk($sformatf("vec%0d credits", i), {28'd0, credits}, tbl[i].cr);
      chk($sformatf("vec%0d active", i),  {31'd0, play_active}, tbl[i].act);
      chk($sformatf("vec%0d secs", i),    {25'd0, seconds_left}, tbl[i].secs);
      chk($sformatf("vec%0d grant", i),   {31'd0, play_grant}, tbl[i].grant);
      chk($sformatf("vec%0d time_up", i), {31'd0, time_up}, tbl[i].tu);
      chk($sformatf("vec%0d n_grant", i), n_grant, tbl[i].n_grant);
      chk($sformatf("vec%0d n_tu", i),    n_tu, tbl[i].n_tu);
      chk($sformatf("vec%0d n_rej", i),   n_rej, tbl[i].n_rej);
    end

    // Full bank: start_req lands on the same cycle as the coin event.
    coin_in = 1'b1;
    step(6);
    start_req = 1'b1;
    step(1);
    start_req = 1'b0;
    chk("same-cycle grant",   {31'd0, play_grant}, 1);
    chk("same-cycle credits", {28'd0, credits}, 9);
    chk("same-cycle reject",  {31'd0, coin_reject}, 0);
    chk("same-cycle secs",    {25'd0, seconds_left}, 30);
    step(3);
    coin_in = 1'b0;
    step(10);
    chk("same-cycle credits after", {28'd0, credits}, 9);
    chk("same-cycle n_rej", n_rej, 1);
    chk("same-cycle n_grant", n_grant, 3);

    // play_done on the cycle of the final decrement beats time_up.
    step(586);
    chk("last second", {25'd0, seconds_left}, 1);
    play_done = 1'b1;
    step(1);
    play_done = 1'b0;
    chk("race active",  {31'd0, play_active}, 0);
    chk("race secs",    {25'd0, seconds_left}, 0);
    chk("race time_up", {31'd0, time_up}, 0);
    step(2);
    chk("race n_tu", n_tu, 1);

    // Asynchronous reset mid-play.
    start_req = 1'b1;
    step(1);
    start_req = 1'b0;
    chk("play3 credits", {28'd0, credits}, 8);
    step(360);
    chk("play3 secs", {25'd0, seconds_left}, 12);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async grant",   {31'd0, play_grant}, 0);
    chk("async active",  {31'd0, play_active}, 0);
    chk("async time_up", {31'd0, time_up}, 0);
    chk("async reject",  {31'd0, coin_reject}, 0);
    chk("async credits", {28'd0, credits}, 0);
    chk("async secs",    {25'd0, seconds_left}, 0);
    step(2);
    rst_n = 1'b1;
    step(1);
    chk("post-reset active",  {31'd0, play_active}, 0);
    chk("post-reset credits", {28'd0, credits}, 0);
    start_req = 1'b1;
    step(1);
    start_req = 1'b0;
    chk("post-reset grant",  {31'd0, play_grant}, 0);
    chk("post-reset active2", {31'd0, play_active}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
